walk_service_fsm: RTL

- Consumer end of the pedestrian walk-request interface. Watches `wr` from the walk request register and waits for the main controller to open a walk window.
- When both are present, it acknowledges the request with a one-cycle `wr_reset` pulse, then runs the walk lamp for a fixed time and flashes it.
- Finishes by handing control back to the main traffic FSM with a `walk_done` pulse.
- All timing is counted in `tick` enables (1 Hz divider output), not raw clocks.

---
 rtl/walk_service_fsm_if.sv | 55 +++++
 rtl/walk_service_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/walk_service_fsm_if.sv
// ---------------------------------------------------------------------------
// walk_service_fsm_if
//
// Bundles the signals exchanged between the walk service block and its
// surroundings (the walk request register, the main traffic controller and
// the 1 Hz tick divider).
//
// Signals:
//   tick         1 Hz one-clock timing enable from the divider
//   wr           pending walk request held by the walk request register
//   walk_window  main controller grants the pedestrian crossing
//   wr_reset     one-clock pulse that clears the walk request register
//   walk_lamp    steady walk indication
//   walk_flash   flashing walk indication
//   walk_done    one-clock pulse handing control back to the main controller
//   busy         walk service in progress (any state but idle)
//
// Modports:
//   master  the environment side: drives tick/wr/walk_window, sees the lamps
//   slave   the walk service block itself
// ---------------------------------------------------------------------------
interface walk_service_fsm_if;

   logic tick;
   logic wr;
   logic walk_window;
   logic wr_reset;
   logic walk_lamp;
   logic walk_flash;
   logic walk_done;
   logic busy;

   modport master (
      output tick,
      output wr,
      output walk_window,
      input  wr_reset,
      input  walk_lamp,
      input  walk_flash,
      input  walk_done,
      input  busy
   );

   modport slave (
      input  tick,
      input  wr,
      input  walk_window,
      output wr_reset,
      output walk_lamp,
      output walk_flash,
      output walk_done,
      output busy
   );

endinterface

// File: rtl/walk_service_fsm.sv
// ---------------------------------------------------------------------------
// walk_service_fsm
//
// Consumer end of the pedestrian walk-request path. Waits until a walk
// request is pending and the main controller has opened a walk window,
// acknowledges the request with a one-clock wr_reset pulse, runs the steady
// walk lamp for WALK_TIME ticks, flashes it for FLASH_TIME ticks and then
// reports completion with a one-clock walk_done pulse.
//
// All phase timing is measured in tick enables, not raw clocks.
//
// Parameters:
//   WALK_TIME   ticks spent with the steady walk lamp on (1 .. 2^CNT_W-1)
//   FLASH_TIME  ticks spent in the flashing phase      (1 .. 2^CNT_W-1)
//   CNT_W       width of the tick down-counter
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      walk_service_fsm_if.slave (tick, wr, walk_window in;
//            wr_reset, walk_lamp, walk_flash, walk_done, busy out)
// ---------------------------------------------------------------------------
module walk_service_fsm #(
   parameter int WALK_TIME  = 4,
   parameter int FLASH_TIME = 3,
   parameter int CNT_W      = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   walk_service_fsm_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACK   = 3'd1,
      WALK  = 3'd2,
      FLASH = 3'd3,
      DONE  = 3'd4
   } state_t;

   // The counter holds "ticks remaining minus one", so a phase of N ticks
   // is loaded with N-1 and ends on the tick that finds it at zero.
   localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TIME - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              flash_on;
   logic              flash_on_nxt;

   logic              wr_reset_nxt;
   logic              walk_lamp_nxt;
   logic              walk_flash_nxt;
   logic              walk_done_nxt;
   logic              busy_nxt;

   logic              wr_reset_q;
   logic              walk_lamp_q;
   logic              walk_flash_q;
   logic              walk_done_q;
   logic              busy_q;

   // State, counter and flash phase register. The reset is asynchronous so
   // that pulling reset_n low mid-service darkens the lamps immediately,
   // without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         flash_on <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         flash_on <= flash_on_nxt;
      end
   end

   // Next-state logic. Ticks only matter in WALK and FLASH; a tick that
   // lands while acknowledging is simply dropped so that WALK always gets
   // its full complement of ticks. Once the request has been acknowledged
   // the walk window is no longer consulted: the main controller keeps the
   // vehicle lanes red until walk_done, so the service always completes.
   // The counter only counts down while nonzero, so it can never wrap.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      flash_on_nxt = flash_on;

      case (state)
         IDLE: begin
            if (bus.wr && bus.walk_window) begin
               state_nxt = ACK;
            end
         end

         ACK: begin
            state_nxt = WALK;
            cnt_nxt   = WALK_LOAD;
         end

         WALK: begin
            if (bus.tick) begin
               if (cnt == '0) begin
                  state_nxt    = FLASH;
                  cnt_nxt      = FLASH_LOAD;
                  flash_on_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end

         FLASH: begin
            if (bus.tick) begin
               if (cnt == '0) begin
                  state_nxt    = DONE;
                  flash_on_nxt = 1'b0;
               end else begin
                  cnt_nxt      = cnt - CNT_ONE;
                  flash_on_nxt = ~flash_on;
               end
            end
         end

         DONE: begin
            state_nxt    = IDLE;
            flash_on_nxt = 1'b0;
         end

         default: begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            flash_on_nxt = 1'b0;
         end
      endcase
   end

   // Output decode is done on the next state so that the output flops
   // below line up cycle-for-cycle with the state register. This keeps every
   // output a direct flop output with no path from the inputs.
   always_comb begin
      wr_reset_nxt   = 1'b0;
      walk_lamp_nxt  = 1'b0;
      walk_flash_nxt = 1'b0;
      walk_done_nxt  = 1'b0;
      busy_nxt       = 1'b0;

      case (state_nxt)
         IDLE: begin
            busy_nxt = 1'b0;
         end

         ACK: begin
            wr_reset_nxt = 1'b1;
            busy_nxt     = 1'b1;
         end

         WALK: begin
            walk_lamp_nxt = 1'b1;
            busy_nxt      = 1'b1;
         end

         FLASH: begin
            walk_flash_nxt = flash_on_nxt;
            busy_nxt       = 1'b1;
         end

         DONE: begin
            walk_done_nxt = 1'b1;
            busy_nxt      = 1'b1;
         end

         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   // Output register. Shares the asynchronous reset with the state register
   // so both fall back to the idle picture together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_reset_q   <= 1'b0;
         walk_lamp_q  <= 1'b0;
         walk_flash_q <= 1'b0;
         walk_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         wr_reset_q   <= wr_reset_nxt;
         walk_lamp_q  <= walk_lamp_nxt;
         walk_flash_q <= walk_flash_nxt;
         walk_done_q  <= walk_done_nxt;
         busy_q       <= busy_nxt;
      end
   end

   assign bus.wr_reset   = wr_reset_q;
   assign bus.walk_lamp  = walk_lamp_q;
   assign bus.walk_flash = walk_flash_q;
   assign bus.walk_done  = walk_done_q;
   assign bus.busy       = busy_q;

endmodule
